// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch, multi-cycle multiply, memory wait, HALT drain.
// Optional macro PIPE_HAZARD_PERF_EN adds stall_count/flush_count performance counters.
module pipe_hazard_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int ZERO_REG   = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs2,
  input  logic        id_halt,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mul_start,
  input  logic        ex_branch_taken,
  input  logic        mem_wait,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        mul_busy,
  output logic        halted,
  output logic [1:0]  state
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
`endif
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_MUL    = 2'd1,
    S_DRAIN  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  localparam logic [4:0] ZREG     = 5'(ZERO_REG);
  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 2);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       load_use;
  logic       mul_stall;

  assign state = state_q;

  assign load_use = ex_is_load && (ex_rd != ZREG) &&
                    ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

  // A multiply stalls on entry from RUN and for every MUL cycle before the release cycle.
  assign mul_stall = ((state_q == S_RUN) && ex_mul_start) ||
                     ((state_q == S_MUL) && (cnt_q != 4'd0));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    mul_busy    = 1'b0;
    halted      = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;

    if (reset) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
      {ifid_flush, idex_flush, exmem_flush}          = 3'b111;
      state_d = S_RUN;
      cnt_d   = 4'd0;
    end else if (state_q == S_HALTED) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
      halted = 1'b1;
    end else if (mem_wait) begin
      // Everything freezes; the multiply is still considered in progress.
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
      mul_busy = (state_q == S_MUL) && (cnt_q != 4'd0);
    end else if (mul_stall) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_flush = 1'b1;
      mul_busy    = 1'b1;
      state_d     = S_MUL;
      cnt_d       = (state_q == S_RUN) ? MUL_LOAD : cnt_q - 4'd1;
    end else if (state_q == S_DRAIN) begin
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
      if (cnt_q == 4'd0) state_d = S_HALTED;
      else               cnt_d   = cnt_q - 4'd1;
    end else begin
      // RUN without a multiply, or the MUL release cycle.
      state_d = S_RUN;
      if (ex_branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (id_halt) begin
        pc_en      = 1'b0;
        ifid_flush = 1'b1;
        cnt_d      = 4'd2;
        state_d    = S_DRAIN;
      end else if (load_use) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= 32'd0;
      flush_count <= 32'd0;
    end else begin
      if (!pc_en && (state_q != S_HALTED)) stall_count <= stall_count + 32'd1;
      if (idex_flush)                      flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, then random stimulus against an age-based reference model.
module tb_pipe_hazard_ctrl;
  localparam int MUL_CYCLES = 4;
  localparam int ZERO_REG   = 31;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_uses_rs2 = 1'b0, id_halt = 1'b0, ex_is_load = 1'b0;
  logic       ex_mul_start = 1'b0, ex_branch_taken = 1'b0, mem_wait = 1'b0;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic       ifid_flush, idex_flush, exmem_flush, mul_busy, halted;
  logic [1:0] state;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_count, flush_count;
`endif

  // Observation vector: {pc,ifid,idex,exmem,memwb enables, ifid,idex,exmem flushes, mul_busy, halted, state}
  logic [11:0] obs;
  assign obs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                ifid_flush, idex_flush, exmem_flush, mul_busy, halted, state};

  pipe_hazard_ctrl #(.MUL_CYCLES(MUL_CYCLES), .ZERO_REG(ZERO_REG)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2), .id_halt(id_halt),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_mul_start(ex_mul_start),
    .ex_branch_taken(ex_branch_taken), .mem_wait(mem_wait),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .mul_busy(mul_busy), .halted(halted), .state(state)
`ifdef PIPE_HAZARD_PERF_EN
    , .stall_count(stall_count), .flush_count(flush_count)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        u2;
    logic        halt;
    logic        ld;
    logic [4:0]  rd;
    logic        mul;
    logic        br;
    logic        mw;
    logic [11:0] exp;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Reference model: ages of the multiply in EX and of the HALT since it entered ID (-1 = none).
  int mul_age  = -1;
  int halt_age = -1;

  function automatic vec_t mk(input logic r, input logic [4:0] a, input logic [4:0] b,
                              input logic u, input logic h, input logic l, input logic [4:0] d,
                              input logic m, input logic br, input logic w, input logic [11:0] e);
    vec_t v;
    v.rst = r; v.rs1 = a; v.rs2 = b; v.u2 = u; v.halt = h; v.ld = l; v.rd = d;
    v.mul = m; v.br = br; v.mw = w; v.exp = e;
    return v;
  endfunction

  // Returns expected outputs for this cycle and advances the model across the next edge.
  task automatic model_eval(input vec_t v, output logic [11:0] e);
    logic [4:0] en;
    logic [2:0] fl;
    logic       mb, hl, lu;
    logic [1:0] st;
    int m, h;
    en = 5'b11111; fl = 3'b000; mb = 1'b0; hl = 1'b0;
    m = mul_age; h = halt_age;
    st = (h >= 4) ? 2'd3 : (h >= 1) ? 2'd2 : (m >= 1) ? 2'd1 : 2'd0;
    lu = v.ld && (v.rd != 5'(ZERO_REG)) && ((v.rd == v.rs1) || (v.u2 && (v.rd == v.rs2)));
    if (v.rst) begin
      en = 5'b00000; fl = 3'b111; mul_age = -1; halt_age = -1;
    end else if (h >= 4) begin
      en = 5'b00000; hl = 1'b1;
    end else if (v.mw) begin
      en = 5'b00000; mb = (m >= 1) && (m < MUL_CYCLES - 1);
    end else if (h >= 1) begin
      en = 5'b01111; fl = 3'b100; halt_age = h + 1;
    end else begin
      if (m < 0 && v.mul) m = 0;
      if (m >= 0 && m < MUL_CYCLES - 1) begin
        en = 5'b00011; fl = 3'b001; mb = 1'b1; mul_age = m + 1;
      end else begin
        mul_age = -1;
        if (v.br) fl = 3'b110;
        else if (v.halt) begin en = 5'b01111; fl = 3'b100; halt_age = 1; end
        else if (lu) begin en = 5'b00111; fl = 3'b010; end
      end
    end
    e = {en, fl, mb, hl, st};
  endtask

  // Driver: drive just after the rising edge, sample mid-cycle.
  task automatic apply(input vec_t v);
    @(posedge clk);
    #1;
    reset = v.rst; id_rs1 = v.rs1; id_rs2 = v.rs2; id_uses_rs2 = v.u2; id_halt = v.halt;
    ex_is_load = v.ld; ex_rd = v.rd; ex_mul_start = v.mul; ex_branch_taken = v.br; mem_wait = v.mw;
    #4;
  endtask

  task automatic check(input string name, input int idx, input logic [11:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got=%b expected=%b", name, idx, obs, exp);
    end
  endtask

  vec_t tbl[$];
  vec_t v;
  logic [11:0] e;

  initial begin
    // enable_flush_mulbusy_halted_state
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'b00000_111_0_0_00)); // reset held
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'b00000_111_0_0_00));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'b11111_000_0_0_00)); // run
    tbl.push_back(mk(0, 5, 0, 0, 0, 1, 5, 0, 0, 0, 12'b00111_010_0_0_00)); // load-use rs1
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'b11111_000_0_0_00));
    tbl.push_back(mk(0, 31, 0, 0, 0, 1, 31, 0, 0, 0, 12'b11111_000_0_0_00)); // zero reg
    tbl.push_back(mk(0, 1, 7, 0, 0, 1, 7, 0, 0, 0, 12'b11111_000_0_0_00)); // rs2 unused
    tbl.push_back(mk(0, 1, 7, 1, 0, 1, 7, 0, 0, 0, 12'b00111_010_0_0_00)); // rs2 used
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 12'b00011_001_1_0_00)); // mul entry
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 12'b00011_001_1_0_01));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 12'b00000_000_1_0_01)); // mem_wait freeze
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 12'b00000_000_1_0_01));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 12'b00011_001_1_0_01));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 12'b11111_000_0_0_01)); // release
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'b11111_000_0_0_00));
    tbl.push_back(mk(0, 5, 0, 0, 0, 1, 5, 0, 1, 0, 12'b11111_110_0_0_00)); // branch beats load-use
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 12'b01111_100_0_0_00)); // halt
    tbl.push_back(mk(0, 5, 0, 0, 0, 1, 5, 0, 1, 0, 12'b01111_100_0_0_10)); // drain ignores events
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'b01111_100_0_0_10));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'b01111_100_0_0_10));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'b00000_000_0_1_11)); // halted
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 12'b00000_000_0_1_11));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'b00000_111_0_0_11)); // reset exits
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'b11111_000_0_0_00));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 12'b00011_001_1_0_00)); // mul, then
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'b00011_001_1_0_01));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'b00011_001_1_0_01));
    tbl.push_back(mk(0, 3, 0, 0, 0, 1, 3, 0, 0, 0, 12'b00111_010_0_0_01)); // load-use on release
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'b11111_000_0_0_00));

    // Preamble: one reset edge so the state register is known before checking.
    v = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'b0);
    apply(v);
    model_eval(v, e);

    foreach (tbl[i]) begin
      apply(tbl[i]);
      check("vec", i, tbl[i].exp);
      model_eval(tbl[i], e);
    end

    for (int i = 0; i < 2000; i++) begin
      v.rst  = ($urandom_range(0, 39) == 0);
      v.rs1  = ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
      v.rs2  = ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
      v.rd   = ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
      v.u2   = 1'($urandom_range(0, 1));
      v.ld   = 1'($urandom_range(0, 1));
      v.halt = ($urandom_range(0, 29) == 0);
      v.mul  = ($urandom_range(0, 5) == 0);
      v.br   = ($urandom_range(0, 5) == 0);
      v.mw   = ($urandom_range(0, 4) == 0);
      v.exp  = 12'b0;
      apply(v);
      model_eval(v, e);
      check("rand", i, e);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
